gsm_mac_accum: RTL and testbench

Sequential signed multiply-accumulate back end for the GSM arithmetic datapath. It consumes the stream of signed products from the combinational signed multipliers, for example the 16x16 -> 32-bit product. It sums a fixed number N of products into a wide accumulator, then rounds, arithmetic-shifts and saturates the sum to a 16-bit GSM-style result. Both sides use valid/ready handshakes, so the block can sit between a product source and a filter/quantiser stage with backpressure.

---
 rtl/gsm_mac_accum.sv | 129 ++++++++++++
 tb/tb_gsm_mac_accum.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gsm_mac_accum.sv
// gsm_mac_accum: sums N signed products into a wide accumulator, then rounds half up,
// arithmetic-shifts and saturates the sum to an OUT_W-bit result. Both sides use
// valid/ready handshakes; a result is held until the consumer takes it.
module gsm_mac_accum #(
  parameter int unsigned PW    = 32,
  parameter int unsigned N     = 8,
  parameter int unsigned ACC_W = 40,
  parameter int unsigned SHIFT = 15,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CntLast = CW'(N - 1);

  // Rounding constant 2^(SHIFT-1) at ACC_W+1 bits.
  localparam logic [ACC_W:0] RoundK = (ACC_W + 1)'(1) << (SHIFT - 1);

  // Clip bounds for the shifted sum, expressed at ACC_W+1 bits.
  localparam logic signed [ACC_W:0] MaxQ = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] MinQ = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic [OUT_W-1:0] MaxOut = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] MinOut = {1'b1, {(OUT_W - 1){1'b0}}};

  typedef enum logic {StAcc, StOut} state_e;

  state_e state_q, state_d;

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [OUT_W-1:0]        data_q, data_d;
  logic                    sat_q, sat_d;

  logic                    accept;
  logic                    last;
  logic [ACC_W-1:0]        prod_ext;
  logic [ACC_W-1:0]        sum;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   q;

  assign accept   = in_valid && in_ready;
  assign last     = accept && (cnt_q == CntLast);
  assign prod_ext = {{(ACC_W - PW){in_prod[PW-1]}}, in_prod};
  // The width rule on ACC_W guarantees this sum never wraps.
  assign sum      = acc_q + prod_ext;
  // One extra bit so adding the rounding constant to a near-full-scale sum cannot wrap.
  assign rnd      = {sum[ACC_W-1], sum} + RoundK;
  assign q        = rnd >>> SHIFT;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StAcc;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: N accepts move to OUT, the output handshake returns to ACC.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAcc: if (last) state_d = StOut;
      StOut: if (out_ready) state_d = StAcc;
      default: state_d = StAcc;
    endcase
  end

  // Handshake outputs decoded from state; in_ready is forced low while reset is held.
  always_comb begin
    in_ready  = (state_q == StAcc) && !rst;
    out_valid = (state_q == StOut);
  end

  // Datapath next-state: accumulate, and on the Nth product round/shift/saturate.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    sat_d  = sat_q;
    if (accept) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
        if (q > MaxQ) begin
          data_d = MaxOut;
          sat_d  = 1'b1;
        end else if (q < MinQ) begin
          data_d = MinOut;
          sat_d  = 1'b1;
        end else begin
          data_d = q[OUT_W-1:0];
          sat_d  = 1'b0;
        end
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      sat_q  <= sat_d;
    end
  end

  assign out_data = data_q;
  assign out_sat  = sat_q;

endmodule

// File: tb/tb_gsm_mac_accum.sv
// Self-checking bench for gsm_mac_accum: directed batch table, random batches against a
// plain-arithmetic reference model, and hand-written handshake/reset sequences.
module tb_gsm_mac_accum;

  localparam int unsigned PW    = 32;
  localparam int unsigned N     = 8;
  localparam int unsigned ACC_W = 40;
  localparam int unsigned SHIFT = 15;
  localparam int unsigned OUT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    in_prod;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;

  int n_checks;
  int n_fails;

  gsm_mac_accum #(
    .PW(PW), .N(N), .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0]    prod;
    logic [OUT_W-1:0] data;
    logic             sat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: round half up, arithmetic shift, clip to OUT_W signed.
  task automatic model(input longint s, output logic [OUT_W-1:0] d, output logic sat);
    longint r;
    longint qq;
    r  = s + (longint'(1) << (SHIFT - 1));
    qq = r >>> SHIFT;
    if (qq > 32767) begin
      d = 16'h7FFF; sat = 1'b1;
    end else if (qq < -32768) begin
      d = 16'h8000; sat = 1'b1;
    end else begin
      d = qq[15:0]; sat = 1'b0;
    end
  endtask

  // Present one product until accepted (bounded).
  task automatic send(input logic [PW-1:0] p);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_prod  = p;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_batch(input logic [PW-1:0] p);
    for (int i = 0; i < N; i++) send(p);
  endtask

  // Result must already be visible; take it and confirm in_ready returns next cycle.
  task automatic take_result(input string name, input logic [OUT_W-1:0] d, input logic s);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_data"}, 64'(out_data), 64'(d));
    check({name, "_sat"}, 64'(out_sat), 64'(s));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_valid_clr"}, 64'(out_valid), 64'd0);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  vec_t vecs[7];

  initial begin
    logic [OUT_W-1:0] md;
    logic             ms;
    logic [OUT_W-1:0] held;
    longint           msum;
    int               acc_n;

    vecs[0] = '{32'h0000_0800, 16'h0001, 1'b0};
    vecs[1] = '{32'h0000_8000, 16'h0008, 1'b0};
    vecs[2] = '{32'hFFFF_F800, 16'h0000, 1'b0};
    vecs[3] = '{32'hFFFF_F000, 16'hFFFF, 1'b0};
    vecs[4] = '{32'h4000_0000, 16'h7FFF, 1'b1};
    vecs[5] = '{32'h8000_0000, 16'h8000, 1'b1};
    vecs[6] = '{32'h0000_0000, 16'h0000, 1'b0};

    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Directed batches.
    for (int v = 0; v < 7; v++) begin
      send_batch(vecs[v].prod);
      take_result($sformatf("vec%0d", v), vecs[v].data, vecs[v].sat);
    end

    // Backpressure: result held, in_ready low, presented products ignored.
    send_batch(32'h0000_8000);
    held     = out_data;
    in_valid = 1'b1;
    in_prod  = 32'h7FFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'h0008);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_ready_back", 64'(in_ready), 64'd1);
    check("bp_data_kept", 64'(out_data), 64'(held));
    send_batch(32'h0000_0800);
    take_result("bp_next", 16'h0001, 1'b0);

    // Random batches with input bubbles against the model.
    for (int b = 0; b < 6; b++) begin
      msum  = 0;
      acc_n = 0;
      for (int c = 0; c < 200 && acc_n < N; c++) begin
        in_valid = 1'($urandom_range(0, 1));
        in_prod  = PW'($signed($urandom) >>> $urandom_range(0, 20));
        if (in_valid && in_ready) begin
          msum += longint'($signed(in_prod));
          acc_n++;
        end
        tick();
      end
      in_valid = 1'b0;
      check("rnd_count", 64'(acc_n), 64'(N));
      model(msum, md, ms);
      take_result($sformatf("rnd%0d", b), md, ms);
    end

    // Async reset mid-accumulation while a nonzero result is still held.
    send_batch(32'h0000_8000);
    take_result("pre_rst", 16'h0008, 1'b0);
    for (int i = 0; i < 3; i++) send(32'h7FFF_FFFF);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_data", 64'(out_data), 64'd0);
    check("mid_rst_sat", 64'(out_sat), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick();
    send_batch(32'h0000_0800);
    take_result("after_mid_rst", 16'h0001, 1'b0);

    // Async reset while holding a result.
    send_batch(32'h4000_0000);
    check("out_hold_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("out_rst_valid", 64'(out_valid), 64'd0);
    check("out_rst_sat", 64'(out_sat), 64'd0);
    check("out_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("out_rst_ready_back", 64'(in_ready), 64'd1);
    tick();
    send_batch(32'hFFFF_F000);
    take_result("after_out_rst", 16'hFFFF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
